// File: rtl/foreground_line_scheduler_if.sv
// Fill-request handshake between the foreground line scheduler
// and the scanline fill unit.
interface foreground_line_scheduler_if;
  logic       req_valid_o;
  logic       req_ready_i;
  logic [7:0] req_x_o;
  logic [4:0] req_pmfa_o;
  logic [2:0] req_row_o;
  logic       req_hflip_o;
  logic [2:0] req_color_o;

  modport master (
    output req_valid_o,
    output req_x_o,
    output req_pmfa_o,
    output req_row_o,
    output req_hflip_o,
    output req_color_o,
    input  req_ready_i
  );

  modport slave (
    input  req_valid_o,
    input  req_x_o,
    input  req_pmfa_o,
    input  req_row_o,
    input  req_hflip_o,
    input  req_color_o,
    output req_ready_i
  );
endinterface

// File: rtl/foreground_line_scheduler.sv
// Per-line sprite evaluator: scans OBM Y bytes, buffers hits in a
// LIFO, then fetches and issues one fill request per hit.
module foreground_line_scheduler #(
  parameter int NUM_OBJECTS   = 64,
  parameter int MAX_PER_LINE  = 16,
  parameter int MAX_VISIBLE_Y = 239
) (
  input  logic       gpu_clk,
  input  logic       rst,
  input  logic       line_start_i,
  input  logic [8:0] next_y_i,
  output logic [7:0] obm_addr_o,
  input  logic [7:0] obm_data_i,
  foreground_line_scheduler_if.master req,
  output logic       busy_o,
  output logic       done_o,
  output logic       overflow_o,
  output logic [5:0] count_o
);

  localparam int KW = $clog2(NUM_OBJECTS);
  localparam int SW = $clog2(MAX_PER_LINE) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FETCH,
    ISSUE,
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [4:0] pmfa;
    logic [2:0] row;
    logic       hflip;
    logic [2:0] color;
  } fill_req_t;

  state_t        state;
  state_t        state_n;
  logic [8:0]    line_y;
  logic [7:0]    addr;
  logic          addr_v;
  logic [KW:0]   nxt_k;
  logic          rd_v;
  logic [KW-1:0] rd_k;
  logic [KW-1:0] lifo [MAX_PER_LINE];
  logic [SW-1:0] sp;
  logic [SW-1:0] sp_m1;
  logic [SW-1:0] sp_m2;
  logic [5:0]    cnt;
  logic          ovf;
  logic [2:0]    ph;
  logic [7:0]    y_q;
  logic [2:0]    row_raw;
  fill_req_t     fr;

  logic          hit;
  logic          full;
  logic          push;
  logic          last_eval;
  logic [KW-1:0] tgt;
  logic          valid;
  logic          busy;
  logic          done;

  function automatic logic [7:0] mk_addr(
    input logic [KW-1:0] k,
    input logic [1:0]    b
  );
    return {6'(k), b};
  endfunction

  assign sp_m1   = sp - SW'(1);
  assign sp_m2   = sp - SW'(2);
  assign row_raw = 3'(line_y - {1'b0, y_q});

  always_comb begin
    hit = rd_v
       && (line_y <= 9'(MAX_VISIBLE_Y))
       && (line_y >= {1'b0, obm_data_i})
       && (line_y <= ({1'b0, obm_data_i} + 9'd7));
  end

  assign full      = (sp == SW'(MAX_PER_LINE));
  assign push      = (state == SCAN) && hit && !full;
  assign last_eval = (state == SCAN) && rd_v
                  && (rd_k == KW'(NUM_OBJECTS - 1));

  // Next object to fetch: the entry that will be on top after
  // this cycle's push (end of scan) or pop (after a handshake).
  always_comb begin
    tgt = lifo[sp_m2[SW-2:0]];
    if (state == SCAN) begin
      if (push) tgt = rd_k;
      else      tgt = lifo[sp_m1[SW-2:0]];
    end
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    valid   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state)
      IDLE: busy = 1'b0;
      SCAN: begin
        if (last_eval)
          state_n = ((sp != '0) || push) ? FETCH : DONE;
      end
      FETCH: begin
        if (ph == 3'd4) state_n = ISSUE;
      end
      ISSUE: begin
        valid = 1'b1;
        if (req.req_ready_i)
          state_n = (sp > SW'(1)) ? FETCH : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (line_start_i) state_n = SCAN;
  end

  always_ff @(posedge gpu_clk) begin
    if (push) lifo[sp[SW-2:0]] <= rd_k;
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      line_y <= '0;
      addr   <= '0;
      addr_v <= 1'b0;
      nxt_k  <= '0;
      rd_v   <= 1'b0;
      rd_k   <= '0;
      sp     <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      ph     <= '0;
      y_q    <= '0;
      fr     <= '0;
    end else if (line_start_i) begin
      line_y <= next_y_i;
      addr   <= mk_addr('0, 2'd1);
      addr_v <= 1'b1;
      nxt_k  <= (KW+1)'(1);
      rd_v   <= 1'b0;
      sp     <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      ph     <= '0;
    end else begin
      rd_v <= 1'b0;
      unique case (state)
        SCAN: begin
          rd_v <= addr_v;
          rd_k <= addr[2+:KW];
          if (nxt_k < (KW+1)'(NUM_OBJECTS)) begin
            addr  <= mk_addr(nxt_k[KW-1:0], 2'd1);
            nxt_k <= nxt_k + (KW+1)'(1);
          end else begin
            addr_v <= 1'b0;
          end
          if (hit) begin
            if (!full) begin
              sp  <= sp + SW'(1);
              cnt <= cnt + 6'd1;
            end else begin
              ovf <= 1'b1;
            end
          end
          if (last_eval) begin
            addr <= mk_addr(tgt, 2'd0);
            ph   <= '0;
          end
        end
        FETCH: begin
          ph <= ph + 3'd1;
          if (ph < 3'd3)
            addr <= {addr[7:2], ph[1:0] + 2'd1};
          case (ph)
            3'd1: fr.x <= obm_data_i;
            3'd2: y_q  <= obm_data_i;
            3'd3: begin
              fr.pmfa  <= obm_data_i[4:0];
              fr.hflip <= obm_data_i[6];
              fr.row   <= obm_data_i[5] ? ~row_raw : row_raw;
            end
            3'd4: fr.color <= obm_data_i[2:0];
            default: ;
          endcase
        end
        ISSUE: begin
          if (req.req_ready_i) begin
            sp <= sp_m1;
            ph <= '0;
            if (sp > SW'(1))
              addr <= mk_addr(tgt, 2'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign obm_addr_o      = addr;
  assign req.req_valid_o = valid;
  assign req.req_x_o     = fr.x;
  assign req.req_pmfa_o  = fr.pmfa;
  assign req.req_row_o   = fr.row;
  assign req.req_hflip_o = fr.hflip;
  assign req.req_color_o = fr.color;
  assign busy_o          = busy;
  assign done_o          = done;
  assign overflow_o      = ovf;
  assign count_o         = cnt;

endmodule

// File: tb/tb_foreground_line_scheduler.sv
// Directed bench for foreground_line_scheduler with an OBM model
// and a fill-request collector.
module tb_foreground_line_scheduler;

  logic       gpu_clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_start = 1'b0;
  logic [8:0] next_y = '0;
  logic [7:0] obm_addr;
  logic [7:0] obm_data;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [5:0] count;

  foreground_line_scheduler_if req_if();

  foreground_line_scheduler dut (
    .gpu_clk      (gpu_clk),
    .rst          (rst),
    .line_start_i (line_start),
    .next_y_i     (next_y),
    .obm_addr_o   (obm_addr),
    .obm_data_i   (obm_data),
    .req          (req_if),
    .busy_o       (busy),
    .done_o       (done),
    .overflow_o   (overflow),
    .count_o      (count)
  );

  always #5 gpu_clk = ~gpu_clk;

  logic [7:0] mem [256];

  always @(posedge gpu_clk) obm_data <= mem[obm_addr];

  int n_run = 0;
  int n_fail = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pk(
    input logic [7:0] x,
    input logic [4:0] pmfa,
    input logic [2:0] row,
    input logic       hf,
    input logic [2:0] col
  );
    return {x, pmfa, row, hf, col};
  endfunction

  function automatic logic [19:0] cur_req();
    return {req_if.req_x_o, req_if.req_pmfa_o, req_if.req_row_o,
            req_if.req_hflip_o, req_if.req_color_o};
  endfunction

  logic [19:0] got_q [$];
  int          done_cyc;
  int          ndone;
  int          stable_err;
  logic [7:0]  a1;
  logic [7:0]  a2;
  logic        b1;
  logic        v1;

  function automatic logic [19:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return '1;
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 64; k++) begin
      mem[k*4+0] = 8'h00;
      mem[k*4+1] = 8'hFF;
      mem[k*4+2] = 8'h00;
      mem[k*4+3] = 8'h00;
    end
  endtask

  task automatic set_obj(
    input int k,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [7:0] attr,
    input logic [7:0] col
  );
    mem[k*4+0] = x;
    mem[k*4+1] = y;
    mem[k*4+2] = attr;
    mem[k*4+3] = col;
  endtask

  task automatic setup_three(input logic [7:0] attr40);
    clear_mem();
    set_obj(3, 8'd10, 8'd96, 8'h03, 8'd1);
    set_obj(7, 8'd20, 8'd100, 8'h11, 8'd2);
    set_obj(40, 8'd30, 8'd93, attr40, 8'd6);
  endtask

  task automatic run_line(
    input logic [8:0] y,
    input int         stall,
    input bit         abort
  );
    logic [19:0] snap;
    int          left;
    bit          seen;
    got_q.delete();
    done_cyc   = -1;
    ndone      = 0;
    stable_err = 0;
    left       = stall;
    seen       = 1'b0;
    snap       = '0;
    @(negedge gpu_clk);
    next_y     = y;
    line_start = 1'b1;
    @(posedge gpu_clk);
    #1;
    line_start = 1'b0;
    req_if.req_ready_i = (stall == 0);
    for (int c = 1; c <= 400; c++) begin
      @(negedge gpu_clk);
      if (c == 1) begin
        a1 = obm_addr;
        b1 = busy;
        v1 = req_if.req_valid_o;
      end
      if (c == 2) a2 = obm_addr;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (req_if.req_valid_o) begin
        if (abort) return;
        if (!seen) begin
          seen = 1'b1;
          snap = cur_req();
        end
        if (left > 0) begin
          if (cur_req() !== snap || req_if.req_ready_i)
            stable_err++;
          left--;
        end else begin
          req_if.req_ready_i = 1'b1;
        end
        if (req_if.req_ready_i) got_q.push_back(cur_req());
      end
      if (done_cyc > 0 && c >= done_cyc + 4) break;
    end
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    req_if.req_ready_i = 1'b0;
    rst        = 1'b1;
    line_start = 1'b1;
    next_y     = 9'd100;
    repeat (3) @(posedge gpu_clk);
    @(negedge gpu_clk);
    check("rst_addr", obm_addr, 0);
    check("rst_valid", req_if.req_valid_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_count", count, 0);
    check("rst_req", cur_req(), 0);
    rst        = 1'b0;
    line_start = 1'b0;

    run_line(9'd100, 0, 1'b0);
    check("empty_done_cyc", done_cyc, 66);
    check("empty_ndone", ndone, 1);
    check("empty_count", count, 0);
    check("empty_ovf", overflow, 0);
    check("empty_nreq", got_q.size(), 0);
    check("scan_addr1", a1, 8'h01);
    check("scan_addr2", a2, 8'h05);
    check("busy_c1", b1, 1);

    setup_three(8'h45);
    run_line(9'd100, 0, 1'b0);
    check("three_nreq", got_q.size(), 3);
    check("three_r0", got_at(0), pk(8'd30, 5'd5, 3'd7, 1'b1, 3'd6));
    check("three_r1", got_at(1), pk(8'd20, 5'd17, 3'd0, 1'b0, 3'd2));
    check("three_r2", got_at(2), pk(8'd10, 5'd3, 3'd4, 1'b0, 3'd1));
    check("three_done_cyc", done_cyc, 84);
    check("three_count", count, 3);
    check("three_ovf", overflow, 0);

    setup_three(8'h25);
    run_line(9'd100, 0, 1'b0);
    check("vflip_r0", got_at(0), pk(8'd30, 5'd5, 3'd0, 1'b0, 3'd6));

    setup_three(8'h45);
    run_line(9'd100, 10, 1'b0);
    check("stall_stable", stable_err, 0);
    check("stall_nreq", got_q.size(), 3);
    check("stall_r0", got_at(0), pk(8'd30, 5'd5, 3'd7, 1'b1, 3'd6));
    check("stall_r1", got_at(1), pk(8'd20, 5'd17, 3'd0, 1'b0, 3'd2));
    check("stall_r2", got_at(2), pk(8'd10, 5'd3, 3'd4, 1'b0, 3'd1));
    check("stall_done_cyc", done_cyc, 94);

    clear_mem();
    for (int i = 0; i < 20; i++)
      set_obj(i, 8'(i * 3), 8'd50, 8'(i), 8'(i));
    run_line(9'd55, 0, 1'b0);
    check("full_count", count, 16);
    check("full_ovf", overflow, 1);
    check("full_nreq", got_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] k;
      k = 8'(15 - i);
      check($sformatf("full_r%0d", i), got_at(i),
            pk(8'(k * 3), k[4:0], 3'd5, 1'b0, k[2:0]));
    end
    check("full_done_cyc", done_cyc, 162);

    clear_mem();
    set_obj(5, 8'd7, 8'd232, 8'h00, 8'h00);
    run_line(9'd239, 0, 1'b0);
    check("lastline_count", count, 1);
    check("lastline_r0", got_at(0), pk(8'd7, 5'd0, 3'd7, 1'b0, 3'd0));

    setup_three(8'h45);
    run_line(9'd100, 1000, 1'b1);
    check("abort_in_issue", req_if.req_valid_o, 1);
    run_line(9'd240, 0, 1'b0);
    check("abort_valid_drop", v1, 0);
    check("abort_ndone", ndone, 1);
    check("abort_done_cyc", done_cyc, 66);
    check("abort_nreq", got_q.size(), 0);
    check("abort_count", count, 0);
    check("abort_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
